// File: rtl/usb_sniffer_pkg.sv
// Shared types for the ULPI-to-UART framer: sync bytes,
// descriptor layout and the capture/transmit state encodings.
package usb_sniffer_pkg;

    localparam logic [7:0] SYNC_PKT   = 8'hA5;
    localparam logic [7:0] SYNC_RXCMD = 8'h5A;

    typedef enum logic {
        PKT,
        RXCMD
    } desc_kind_e;

    typedef struct packed {
        desc_kind_e kind;
        logic [7:0] len_or_val;
        logic [7:0] csum;
    } desc_t;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_PKT,
        CAP_DISCARD
    } cap_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_LEN,
        TX_DATA,
        TX_CSUM,
        TX_VAL
    } tx_state_e;

endpackage

// File: rtl/ulpi_frame_fifo.sv
// Payload byte buffer with a commit pointer so a partially captured
// packet can be rolled back; 1-cycle registered read.
module ulpi_frame_fifo
    import usb_sniffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       rollback,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]    mem [2**DEPTH_LOG2];
    logic [7:0]    rd_data_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (commit) begin
                commit_ptr_d = wr_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rollback) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    assign rd_data = rd_data_q;
    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH;

endmodule

// File: rtl/ulpi_uart_framer.sv
// Buffers ULPI packets until EOP, then emits length/checksum framed
// records (and RxCMD status records) to a UART transmitter.
module ulpi_uart_framer
    import usb_sniffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DESC_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_rxcmd,
    input  logic        in_eop,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_full,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);
    localparam int DW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int CW = $clog2(DESC_DEPTH + 1);
    localparam logic [CW-1:0] DESC_MAX = CW'(DESC_DEPTH);

    cap_state_e    cap_q, cap_d;
    tx_state_e     tx_q, tx_d;
    logic [7:0]    len_q, len_d, csum_q, csum_d;
    logic [7:0]    drop_q, drop_d, rem_q, rem_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_send_q, tx_send_d;
    logic [15:0]   frame_q, frame_d;
    desc_t         desc_q [DESC_DEPTH];
    desc_t         desc_d [DESC_DEPTH];
    desc_t         cur_q, cur_d, push_desc;
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, drop_inc, desc_full, can_issue;
    logic [7:0]    len_base, csum_base;
    logic          f_wr, f_commit, f_rollback, f_rd, f_full;
    logic [7:0]    f_rdata;

    function automatic logic [DW-1:0] next_idx(input logic [DW-1:0] p);
        return (p == DW'(DESC_DEPTH - 1)) ? '0 : p + DW'(1);
    endfunction

    ulpi_frame_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (f_wr),
        .wr_data (in_data),
        .commit  (f_commit),
        .rollback(f_rollback),
        .rd_en   (f_rd),
        .rd_data (f_rdata),
        .full    (f_full)
    );

    // Capture side: a full queue is judged on the registered count,
    // so a same-cycle pop never rescues a push.
    always_comb begin
        cap_d      = cap_q;
        len_d      = len_q;
        csum_d     = csum_q;
        push       = 1'b0;
        push_desc  = '0;
        drop_inc   = 1'b0;
        f_wr       = 1'b0;
        f_commit   = 1'b0;
        f_rollback = 1'b0;
        desc_full  = cnt_q == DESC_MAX;
        len_base   = (cap_q == CAP_PKT) ? len_q : 8'd0;
        csum_base  = (cap_q == CAP_PKT) ? csum_q : 8'd0;
        if (in_valid && in_rxcmd) begin
            if (desc_full) begin
                drop_inc = 1'b1;
            end else begin
                push      = 1'b1;
                push_desc = '{kind: RXCMD, len_or_val: in_data, csum: 8'd0};
            end
        end else if (in_valid) begin
            if (cap_q == CAP_DISCARD) begin
                if (in_eop) cap_d = CAP_IDLE;
            end else if (f_full || len_base == 8'hFF || (in_eop && desc_full)) begin
                f_rollback = 1'b1;
                drop_inc   = 1'b1;
                cap_d      = in_eop ? CAP_IDLE : CAP_DISCARD;
            end else begin
                f_wr   = 1'b1;
                len_d  = len_base + 8'd1;
                csum_d = csum_base ^ in_data;
                cap_d  = CAP_PKT;
                if (in_eop) begin
                    f_commit  = 1'b1;
                    push      = 1'b1;
                    push_desc = '{kind: PKT, len_or_val: len_d, csum: csum_d};
                    cap_d     = CAP_IDLE;
                end
            end
        end
        drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // Transmit side: tx_full is re-sampled after every write strobe.
    always_comb begin
        tx_d      = tx_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        frame_d   = frame_q;
        pop       = 1'b0;
        f_rd      = 1'b0;
        can_issue = !tx_full && !tx_send_q;
        unique case (tx_q)
            TX_IDLE: begin
                if (cnt_q != '0 && can_issue) begin
                    pop       = 1'b1;
                    cur_d     = desc_q[head_q];
                    tx_send_d = 1'b1;
                    tx_data_d = (desc_q[head_q].kind == PKT) ? SYNC_PKT : SYNC_RXCMD;
                    tx_d      = TX_SYNC;
                end
            end
            TX_SYNC: begin
                if (can_issue) begin
                    tx_send_d = 1'b1;
                    tx_data_d = cur_q.len_or_val;
                    rem_d     = cur_q.len_or_val;
                    tx_d      = (cur_q.kind == PKT) ? TX_LEN : TX_VAL;
                end
            end
            TX_LEN, TX_DATA: begin
                f_rd = tx_send_q && rem_q != 8'd0;
                if (can_issue) begin
                    tx_send_d = 1'b1;
                    if (rem_q != 8'd0) begin
                        tx_data_d = f_rdata;
                        rem_d     = rem_q - 8'd1;
                        tx_d      = TX_DATA;
                    end else begin
                        tx_data_d = cur_q.csum;
                        tx_d      = TX_CSUM;
                    end
                end
            end
            TX_CSUM, TX_VAL: begin
                frame_d = frame_q + 16'd1;
                tx_d    = TX_IDLE;
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_comb begin
        desc_d = desc_q;
        head_d = pop ? next_idx(head_q) : head_q;
        tail_d = push ? next_idx(tail_q) : tail_q;
        if (push) desc_d[tail_q] = push_desc;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q     <= CAP_IDLE;
            tx_q      <= TX_IDLE;
            len_q     <= '0;
            csum_q    <= '0;
            drop_q    <= '0;
            rem_q     <= '0;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            frame_q   <= '0;
            cur_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
        end else begin
            cap_q     <= cap_d;
            tx_q      <= tx_d;
            len_q     <= len_d;
            csum_q    <= csum_d;
            drop_q    <= drop_d;
            rem_q     <= rem_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            frame_q   <= frame_d;
            cur_q     <= cur_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        desc_q <= desc_d;
    end

    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign busy        = (tx_q != TX_IDLE) || (cnt_q != '0);
    assign frame_count = frame_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_ulpi_uart_framer.sv
// Scoreboard bench: stimulus pushes expected UART bytes from a frame-level
// model; an independent monitor pops and compares every tx_send strobe.
module tb_ulpi_uart_framer;

    localparam int QDEPTH = 4;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_rxcmd = 1'b0;
    logic        in_eop = 1'b0;
    logic        tx_full = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    bit force_full = 1'b0;
    bit rand_full = 1'b0;
    logic prev_send = 1'b0;
    logic prev_full = 1'b0;
    logic [7:0] exp_q[$];
    int send_cyc[$];

    ulpi_uart_framer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_rxcmd   (in_rxcmd),
        .in_eop     (in_eop),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_full    (tx_full),
        .busy       (busy),
        .frame_count(frame_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        tx_full = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must honour the 2-cycle / Tx_FULL rule and
    // match the next expected byte.
    always @(negedge clk) begin
        if (rst) begin
            prev_send = 1'b0;
            prev_full = 1'b0;
        end else begin
            if (tx_send) begin
                check("tx_spacing", {30'd0, prev_send, prev_full}, 32'd0);
                send_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_send = tx_send;
            prev_full = tx_full;
        end
    end

    task automatic put(input logic [7:0] d, input logic r, input logic e);
        in_data  = d;
        in_valid = 1'b1;
        in_rxcmd = r;
        in_eop   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rxcmd = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_data  = 8'($urandom);
            in_eop   = 1'($urandom);
            in_rxcmd = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_rxcmd = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Frame-level reference: a packet becomes A5, LEN, bytes, XOR, or a
    // drop when longer than 255 bytes.
    task automatic exp_pkt(input bq_t b);
        logic [7:0] x;
        x = 8'd0;
        if (b.size() > 255) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(b.size()));
            foreach (b[i]) begin
                exp_q.push_back(b[i]);
                x = x ^ b[i];
            end
            exp_q.push_back(x);
            exp_frames++;
        end
    endtask

    task automatic exp_rx(input logic [7:0] v);
        exp_q.push_back(8'h5A);
        exp_q.push_back(v);
        exp_frames++;
    endtask

    task automatic send_pkt(input bq_t b, input int rx_pos,
                            input logic [7:0] rx_val, input int gapmax);
        int last;
        last = b.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (i == rx_pos) begin
                put(rx_val, 1'b1, 1'($urandom));
                exp_rx(rx_val);
                idle($urandom_range(0, gapmax));
            end
            put(b[i], 1'b0, i == last);
            if (i != last) idle($urandom_range(0, gapmax));
        end
        exp_pkt(b);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'((exp_q.size() != 0) || busy), 32'd0);
        check("frame_count", {16'd0, frame_count}, 32'(exp_frames));
        check("drop_count", {24'd0, drop_count}, 32'(exp_drops));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bq_t b;
        int eop_cyc;
        int base;
        int n;
        logic [7:0] v;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Basic packet, latency and pacing
        send_cyc.delete();
        put(8'h11, 1'b0, 1'b0);
        put(8'h22, 1'b0, 1'b0);
        eop_cyc = cyc;
        put(8'h33, 1'b0, 1'b1);
        b = '{8'h11, 8'h22, 8'h33};
        exp_pkt(b);
        drain(200);
        check("t1_send_count", 32'(send_cyc.size()), 32'd6);
        if (send_cyc.size() == 6) begin
            check("t1_first_latency", 32'(send_cyc[0] - eop_cyc), 32'd2);
            for (int i = 1; i < 6; i++) begin
                check("t1_gap", 32'(send_cyc[i] - send_cyc[i-1]), 32'd2);
            end
        end

        // RxCMD mid-packet is emitted first
        b = '{8'h01, 8'h02};
        send_pkt(b, 1, 8'h4C, 0);
        drain(200);

        // 256-byte packet aborts silently, then a 1-byte packet
        b.delete();
        for (int i = 0; i < 256; i++) b.push_back(8'($urandom));
        send_pkt(b, -1, 8'h00, 0);
        idle(20);
        check("t3_abort_drop", {24'd0, drop_count}, 32'(exp_drops));
        check("t3_abort_idle", {31'd0, busy}, 32'd0);
        b = '{8'h7E};
        send_pkt(b, -1, 8'h00, 0);
        drain(200);

        // Descriptor queue overflow under Tx_FULL
        force_full = 1'b1;
        idle(2);
        for (int i = 0; i < QDEPTH + 1; i++) begin
            v = 8'($urandom);
            put(v, 1'b1, 1'b0);
            if (i < QDEPTH) exp_rx(v);
            else if (exp_drops < 255) exp_drops++;
        end
        idle(5);
        check("t4_held_busy", {31'd0, busy}, 32'd1);
        check("t4_held_drop", {24'd0, drop_count}, 32'(exp_drops));
        force_full = 1'b0;
        drain(300);

        // Reset in the middle of a 10-byte frame
        b.delete();
        for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
        base = send_cyc.size();
        send_pkt(b, -1, 8'h00, 0);
        n = 0;
        while (send_cyc.size() < base + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_data", 32'(send_cyc.size() >= base + 4), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        exp_drops = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_tx_send", {31'd0, tx_send}, 32'd0);
        check("t5_tx_data", {24'd0, tx_data}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_frame_count", {16'd0, frame_count}, 32'd0);
        check("t5_drop_count", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        idle(30);
        b = '{8'hC3, 8'h3C, 8'h99};
        send_pkt(b, -1, 8'h00, 1);
        drain(200);

        // Randomized traffic with random Tx_FULL
        rand_full = 1'b1;
        for (int k = 0; k < 25; k++) begin
            int npk;
            npk = $urandom_range(1, 2);
            for (int p = 0; p < npk; p++) begin
                int len;
                int pos;
                len = $urandom_range(1, 40);
                b.delete();
                for (int i = 0; i < len; i++) b.push_back(8'($urandom));
                pos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
                send_pkt(b, pos, 8'($urandom), 2);
                idle($urandom_range(0, 3));
            end
            drain(4000);
        end
        rand_full = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
